// File: rtl/pid_chn_scheduler_pkg.sv
// Shared definitions for the PID channel scheduler: default word widths and
// small channel-index helpers used by the scheduler and its neighbours.
package pid_chn_scheduler_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_CHN_WIDTH  = 3;

   // True when a channel index addresses an implemented channel.
   function automatic logic chn_in_range(input int chn, input int num_chn);
      return (chn >= 0) && (chn < num_chn);
   endfunction

   // Round-robin successor of a channel index.
   function automatic int next_chn(input int idx, input int num_chn);
      return (idx >= num_chn - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/pid_chn_scheduler_if.sv
// Valid/ready link between the channel scheduler (master) and the shared
// time-multiplexed PID core (slave).
interface pid_chn_scheduler_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CHN_WIDTH  = 3
) ();

   logic                  data_valid_o;
   logic [CHN_WIDTH-1:0]  data_chn_o;
   logic [DATA_WIDTH-1:0] data_fdb_o;
   logic [DATA_WIDTH-1:0] data_ref_o;
   logic                  tready_i;

   modport master (
      output data_valid_o, data_chn_o, data_fdb_o, data_ref_o,
      input  tready_i
   );

   modport slave (
      input  data_valid_o, data_chn_o, data_fdb_o, data_ref_o,
      output tready_i
   );

endinterface

// File: rtl/pid_chn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel at or
// after the pointer, wrapping modulo NUM_CHN. The pointer is owned by the parent.
module rr_arbiter #(
   parameter int NUM_CHN   = 4,
   parameter int CHN_WIDTH = 3
) (
   input  logic [NUM_CHN-1:0]   i_req,
   input  logic [CHN_WIDTH-1:0] i_ptr,
   output logic [NUM_CHN-1:0]   o_grant,
   output logic [CHN_WIDTH-1:0] o_idx
);

   logic w_found;

   // Scan priority positions ptr, ptr+1, ... and take the first requester.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_CHN; i++) begin
         for (int j = 0; j < NUM_CHN; j++) begin
            if (!w_found && i_req[j] && (j == ((int'(i_ptr) + i) % NUM_CHN))) begin
               o_grant[j] = 1'b1;
               o_idx      = CHN_WIDTH'(j);
               w_found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pid_chn_scheduler.sv
// Collects per-channel RPM samples and references and issues one
// feedback/reference pair at a time to the shared PID core, round-robin.
// Also tracks sample overruns and per-channel encoder staleness.
module pid_chn_scheduler
   import pid_chn_scheduler_pkg::*;
#(
   parameter int NUM_CHN    = 4,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CHN_WIDTH  = DEF_CHN_WIDTH,
   parameter int REF_RST    = 0,
   parameter int STALE_CYC  = 1000000,
   parameter int STALE_W    = 20
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_CHN-1:0]            rpm_valid_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
   input  logic                          tr_valid_i,
   input  logic [CHN_WIDTH-1:0]          tr_chn_i,
   input  logic [DATA_WIDTH-1:0]         tr_data_i,
   input  logic [NUM_CHN-1:0]            stop_i,
   input  logic                          ovr_clr_i,
   pid_chn_scheduler_if.master           pid_if,
   output logic [NUM_CHN-1:0]            overrun_o,
   output logic [NUM_CHN-1:0]            stale_o
);

   logic [DATA_WIDTH-1:0] r_sample [NUM_CHN];
   logic [DATA_WIDTH-1:0] r_ref    [NUM_CHN];
   logic [STALE_W-1:0]    r_wdog   [NUM_CHN];
   logic [NUM_CHN-1:0]    r_pend;
   logic [NUM_CHN-1:0]    r_ovr;
   logic [CHN_WIDTH-1:0]  r_ptr;
   logic                  r_valid;
   logic [CHN_WIDTH-1:0]  r_chn;
   logic [DATA_WIDTH-1:0] r_fdb;
   logic [DATA_WIDTH-1:0] r_refo;

   logic [NUM_CHN-1:0]    w_grant;
   logic [CHN_WIDTH-1:0]  w_idx;
   logic                  w_launch;
   logic                  w_ref_we;
   logic [NUM_CHN-1:0]    w_ovr_set;
   logic [DATA_WIDTH-1:0] w_sel_fdb;
   logic [DATA_WIDTH-1:0] w_sel_ref;

   rr_arbiter #(
      .NUM_CHN   (NUM_CHN),
      .CHN_WIDTH (CHN_WIDTH)
   ) u_arb (
      .i_req   (r_pend),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   // Launch decision, overrun detection and winner data selection.
   // The selected sample is the registered one, so a same-cycle strobe on the
   // winner is stored for the next round instead of replacing this launch.
   always_comb begin
      w_launch  = (!r_valid || pid_if.tready_i) && (|r_pend);
      w_ref_we  = tr_valid_i && chn_in_range(int'(tr_chn_i), NUM_CHN);
      w_ovr_set = rpm_valid_i & r_pend & ~(w_launch ? w_grant : '0);
      w_sel_fdb = '0;
      w_sel_ref = '0;
      for (int k = 0; k < NUM_CHN; k++) begin
         if (w_grant[k]) begin
            w_sel_fdb = r_sample[k];
            w_sel_ref = stop_i[k] ? '0 : r_ref[k];
         end
      end
   end

   // Sample capture, pending flags and sticky overrun flags (set beats clear).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pend <= '0;
         r_ovr  <= '0;
         for (int k = 0; k < NUM_CHN; k++) r_sample[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CHN; k++) begin
            if (rpm_valid_i[k]) begin
               r_sample[k] <= rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
               r_pend[k]   <= 1'b1;
            end else if (w_launch && w_grant[k]) begin
               r_pend[k]   <= 1'b0;
            end
         end
         r_ovr <= w_ovr_set | (r_ovr & ~{NUM_CHN{ovr_clr_i}});
      end
   end

   // Reference registers; out-of-range channel writes are dropped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_CHN; k++) r_ref[k] <= DATA_WIDTH'(REF_RST);
      end else begin
         for (int k = 0; k < NUM_CHN; k++) begin
            if (w_ref_we && (tr_chn_i == CHN_WIDTH'(k))) r_ref[k] <= tr_data_i;
         end
      end
   end

   // Output register and round-robin pointer; load and transfer may coincide.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_chn   <= '0;
         r_fdb   <= '0;
         r_refo  <= '0;
         r_ptr   <= '0;
      end else if (w_launch) begin
         r_valid <= 1'b1;
         r_chn   <= w_idx;
         r_fdb   <= w_sel_fdb;
         r_refo  <= w_sel_ref;
         r_ptr   <= CHN_WIDTH'(next_chn(int'(w_idx), NUM_CHN));
      end else if (pid_if.tready_i) begin
         r_valid <= 1'b0;
      end
   end

   // Encoder watchdogs: restart on every sample, saturate at the stale limit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_CHN; k++) r_wdog[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CHN; k++) begin
            if (rpm_valid_i[k])                          r_wdog[k] <= '0;
            else if (r_wdog[k] != STALE_W'(STALE_CYC))   r_wdog[k] <= r_wdog[k] + 1'b1;
         end
      end
   end

   // Stale flags decoded from the saturated watchdog counters.
   always_comb begin
      for (int k = 0; k < NUM_CHN; k++) stale_o[k] = (r_wdog[k] == STALE_W'(STALE_CYC));
   end

   assign overrun_o           = r_ovr;
   assign pid_if.data_valid_o = r_valid;
   assign pid_if.data_chn_o   = r_chn;
   assign pid_if.data_fdb_o   = r_fdb;
   assign pid_if.data_ref_o   = r_refo;

endmodule

// File: tb/tb_pid_chn_scheduler.sv
// Bench for pid_chn_scheduler: directed stimulus pushes the expected pairs into
// a queue; a monitor pops and compares on every accepted transfer.
module tb_pid_chn_scheduler;

   localparam int NCH = 4;
   localparam int DW  = 16;
   localparam int CW  = 3;

   typedef struct {
      logic [CW-1:0] chn;
      logic [DW-1:0] fdb;
      logic [DW-1:0] rf;
   } exp_t;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NCH-1:0]    rpm_valid;
   logic [NCH*DW-1:0] rpm_data;
   logic              tr_valid;
   logic [CW-1:0]     tr_chn;
   logic [DW-1:0]     tr_data;
   logic [NCH-1:0]    stop;
   logic              ovr_clr;
   logic [NCH-1:0]    overrun;
   logic [NCH-1:0]    stale;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   pid_chn_scheduler_if #(.DATA_WIDTH(DW), .CHN_WIDTH(CW)) pif ();

   pid_chn_scheduler #(
      .NUM_CHN(NCH), .DATA_WIDTH(DW), .CHN_WIDTH(CW),
      .REF_RST(0), .STALE_CYC(16), .STALE_W(5)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .rpm_valid_i (rpm_valid),
      .rpm_data_i  (rpm_data),
      .tr_valid_i  (tr_valid),
      .tr_chn_i    (tr_chn),
      .tr_data_i   (tr_data),
      .stop_i      (stop),
      .ovr_clr_i   (ovr_clr),
      .pid_if      (pif),
      .overrun_o   (overrun),
      .stale_o     (stale)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input int f, input int r);
      exp_t e;
      e.chn = CW'(c);
      e.fdb = DW'(f);
      e.rf  = DW'(r);
      q.push_back(e);
   endtask

   task automatic set_rpm(input int k, input int v);
      rpm_valid[k] = 1'b1;
      rpm_data[k*DW +: DW] = DW'(v);
   endtask

   task automatic wr_ref(input int c, input int v);
      tr_valid = 1'b1;
      tr_chn   = CW'(c);
      tr_data  = DW'(v);
      tick();
      tr_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 64'(pif.data_valid_o), 64'd0);
      chk({tag, "_chn"},   64'(pif.data_chn_o),   64'd0);
      chk({tag, "_fdb"},   64'(pif.data_fdb_o),   64'd0);
      chk({tag, "_ref"},   64'(pif.data_ref_o),   64'd0);
      chk({tag, "_ovr"},   64'(overrun),          64'd0);
      chk({tag, "_stale"}, 64'(stale),            64'd0);
   endtask

   // Scoreboard monitor: every accepted pair must match the oldest expectation.
   always @(negedge clk) begin
      if (rstn === 1'b1 && pif.data_valid_o === 1'b1 && pif.tready_i === 1'b1) begin
         if (q.size() == 0) begin
            n_total++;
            $display("FAIL xfer_unexpected: got chn %0d fdb %0h ref %0h expected none",
                     pif.data_chn_o, pif.data_fdb_o, pif.data_ref_o);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("xfer", {29'd0, pif.data_chn_o, pif.data_fdb_o, pif.data_ref_o},
                        {29'd0, e.chn, e.fdb, e.rf});
         end
      end
   end

   initial begin
      logic [CW+2*DW-1:0] held;
      rstn = 1'b0; rpm_valid = '0; rpm_data = '0; tr_valid = 1'b0; tr_chn = '0;
      tr_data = '0; stop = '0; ovr_clr = 1'b0; pif.tready_i = 1'b0;
      #3;
      chk_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      pif.tready_i = 1'b1;

      // Fairness from pointer 0: order 0,1,2,3
      for (int k = 0; k < NCH; k++) begin
         set_rpm(k, 'h10 + k);
         push(k, 'h10 + k, 0);
      end
      tick();
      rpm_valid = '0;
      tick();
      chk("fair_first_valid", 64'(pif.data_valid_o), 64'd1);
      repeat (4) tick();
      chk("fair_drain", 64'(pif.data_valid_o), 64'd0);

      // Single channel, latency one cycle after capture
      wr_ref(2, 'h0100);
      set_rpm(2, 'h00C8);
      push(2, 'h00C8, 'h0100);
      tick();
      rpm_valid = '0;
      chk("single_pend_only", 64'(pif.data_valid_o), 64'd0);
      tick();
      chk("single_valid", 64'(pif.data_valid_o), 64'd1);
      tick();
      chk("single_drop", 64'(pif.data_valid_o), 64'd0);

      // Grant channel 1 to move the pointer to 2, then all four: 2,3,0,1
      set_rpm(1, 'h21);
      push(1, 'h21, 0);
      tick();
      rpm_valid = '0;
      repeat (2) tick();
      for (int k = 0; k < NCH; k++) set_rpm(k, 'h30 + k);
      push(2, 'h32, 'h0100);
      push(3, 'h33, 0);
      push(0, 'h30, 0);
      push(1, 'h31, 0);
      tick();
      rpm_valid = '0;
      repeat (5) tick();
      chk("fair2_drain", 64'(pif.data_valid_o), 64'd0);

      // Backpressure: presented pair holds; overrun set even with clear asserted
      pif.tready_i = 1'b0;
      set_rpm(0, 'hA0);
      push(0, 'hA0, 0);
      tick();
      rpm_valid = '0;
      tick();
      chk("bp_valid", 64'(pif.data_valid_o), 64'd1);
      for (int i = 0; i < 10; i++) begin
         if (i == 1) begin tr_valid = 1'b1; tr_chn = '0; tr_data = 'h0300; end
         if (i == 3) set_rpm(0, 'hA1);
         if (i == 6) begin set_rpm(0, 'hA2); ovr_clr = 1'b1; end
         tick();
         rpm_valid = '0; tr_valid = 1'b0; ovr_clr = 1'b0;
         held = {pif.data_chn_o, pif.data_fdb_o, pif.data_ref_o};
         chk("bp_hold", 64'(held), 64'({3'd0, 16'h00A0, 16'h0000}));
      end
      chk("bp_ovr_prio", 64'(overrun), 64'b0001);
      push(0, 'hA2, 'h0300);
      pif.tready_i = 1'b1;
      repeat (2) tick();
      chk("bp_drain", 64'(pif.data_valid_o), 64'd0);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clear", 64'(overrun), 64'd0);

      // Stop forcing and out-of-range reference writes
      stop = 4'b0010;
      wr_ref(1, 'h0200);
      wr_ref(5, 'hDEAD);
      wr_ref(4, 'hBEEF);
      set_rpm(1, 'h55);
      push(1, 'h55, 0);
      tick();
      rpm_valid = '0;
      tick();
      stop = '0;
      tick();
      set_rpm(0, 'h70);
      set_rpm(1, 'h56);
      push(0, 'h70, 'h0300);
      push(1, 'h56, 'h0200);
      tick();
      rpm_valid = '0;
      repeat (3) tick();

      // Strobe on the channel being launched: old sample goes, new one stays pending
      set_rpm(2, 'h81);
      push(2, 'h81, 'h0100);
      tick();
      set_rpm(2, 'h82);
      push(2, 'h82, 'h0100);
      tick();
      rpm_valid = '0;
      repeat (2) tick();
      chk("launch_strobe_no_ovr", 64'(overrun), 64'd0);
      chk("launch_strobe_drain", 64'(pif.data_valid_o), 64'd0);

      // Watchdog on channel 3 with a 16-cycle limit
      set_rpm(3, 'h90);
      push(3, 'h90, 0);
      tick();
      rpm_valid = '0;
      chk("stale_after_strobe", 64'(stale[3]), 64'd0);
      repeat (15) tick();
      chk("stale_at_15", 64'(stale[3]), 64'd0);
      tick();
      chk("stale_at_16", 64'(stale[3]), 64'd1);
      set_rpm(3, 'h91);
      push(3, 'h91, 0);
      chk("stale_before_edge", 64'(stale[3]), 64'd1);
      tick();
      rpm_valid = '0;
      chk("stale_cleared", 64'(stale[3]), 64'd0);
      repeat (2) tick();

      // Asynchronous reset in the middle of a stalled handshake
      pif.tready_i = 1'b0;
      set_rpm(2, 'hEE);
      tick();
      rpm_valid = '0;
      tick();
      chk("mid_valid", 64'(pif.data_valid_o), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk_reset_outputs("mid_rst");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      pif.tready_i = 1'b1;
      repeat (3) tick();
      chk("no_replay", 64'(pif.data_valid_o), 64'd0);
      chk("queue_empty", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pid_chn_scheduler.md
Name: pid_chn_scheduler

Overview:
Parametrised successor to the fixed four-channel PID input processing. Collects per-channel RPM samples from NUM_CHN encoder readers and holds a per-channel reference written by the UART command path. Issues one feedback/reference pair at a time to the shared time-multiplexed PID core over a valid/ready handshake, with round-robin fairness. Adds behaviour the four-channel version lacks: overrun detection, per-channel stop forcing, and encoder-stale watchdogs.

Parameters:
NUM_CHN, 4, number of motor channels (1..8)
DATA_WIDTH, 16, width of RPM, reference and feedback words
CHN_WIDTH, 3, channel index width; must satisfy 2^CHN_WIDTH >= NUM_CHN
REF_RST, 0, reset value of every reference register
STALE_CYC, 1000000, cycles without rpm_valid_i[k] before stale_o[k] asserts
STALE_W, 20, watchdog counter width; must hold STALE_CYC

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
rpm_valid_i  in  NUM_CHN  one-cycle strobe per channel: new RPM sample
rpm_data_i  in  NUM_CHN*DATA_WIDTH  packed samples; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
tr_valid_i  in  1  reference write strobe from UART controller
tr_chn_i  in  CHN_WIDTH  target channel of reference write
tr_data_i  in  DATA_WIDTH  new reference value
stop_i  in  NUM_CHN  per-channel stop; level-sensitive
ovr_clr_i  in  1  clears all overrun flags
data_valid_o  out  1  pair available to PID core
data_chn_o  out  CHN_WIDTH  channel of presented pair
data_fdb_o  out  DATA_WIDTH  feedback (latest RPM sample)
data_ref_o  out  DATA_WIDTH  reference for that channel
tready_i  in  1  PID core accepts; transfer = data_valid_o & tready_i
overrun_o  out  NUM_CHN  sticky: sample overwritten before it was issued
stale_o  out  NUM_CHN  encoder watchdog expired

Behaviour:
- Reset: data_valid_o=0, data_chn_o=0, data_fdb_o=0, data_ref_o=0, overrun_o=0, stale_o=0. All pending flags 0, all ref regs=REF_RST, RR pointer=0, watchdog counters=0. Reset mid-handshake drops the pending pair; nothing is replayed.
- Sample capture: rpm_valid_i[k] latches sample[k] and sets pend[k]. If pend[k] is already set and channel k is not being launched in that cycle, the sample is overwritten with the newer value and overrun_o[k] is set. Multiple channels may strobe in the same cycle; all are captured.
- Reference write: tr_valid_i with tr_chn_i<NUM_CHN writes ref[tr_chn_i]. Writes with tr_chn_i>=NUM_CHN are ignored silently.
- Output stage: single register. It loads when (!data_valid_o | tready_i) and any pend is set. Winner = first pending channel at or after the RR pointer, wrapping modulo NUM_CHN. On load: data_chn_o=winner, data_fdb_o=sample[winner], data_ref_o = stop_i[winner] ? 0 : ref[winner]. pend[winner] is cleared and the pointer moves to winner+1 (wrapping to 0 after NUM_CHN-1).
- Handshake: while data_valid_o=1 and tready_i=0, all data_* outputs hold stable. Ref writes, stop changes and new samples do not alter a presented pair. With no pending channel, a transfer drops data_valid_o to 0 on the next cycle.
- Back-to-back: a transfer and a load may occur in the same cycle, sustaining 1 pair per cycle.
- Latency: rpm_valid_i sampled at edge t -> pend at t -> data_valid_o at edge t+1 when the output stage is free and the channel wins arbitration.
- Simultaneous rpm_valid_i[k] and launch of k: the launch uses the old sample; the new sample is stored and pend[k] stays 1. No overrun is flagged.
- Overrun: ovr_clr_i clears all flags. A new overrun in the same cycle as the clear takes priority, so that flag stays set.
- Watchdog: counter[k] resets to 0 on rpm_valid_i[k], otherwise increments and saturates at STALE_CYC. stale_o[k] = (counter[k]==STALE_CYC). It deasserts on the cycle after the next rpm_valid_i[k].

Decomposition:
- Shared header pid_sched_defs.vh: default DATA_WIDTH/CHN_WIDTH, channel-index range-check macro, sample-slice macro. These are the same definitions used by the UART controller and PID core.
- One sub-module, rr_arbiter: parametrised NUM_CHN request vector plus pointer in, one-hot grant and encoded index out, purely combinational. The pointer register lives in the parent.

Test Plan:
- Single channel: ref[2]=0x0100, rpm_valid_i[2] with 0x00C8, tready_i=1 -> one cycle later data_valid_o=1, chn=2, fdb=0x00C8, ref=0x0100. Next cycle data_valid_o=0.
- Fairness: all four channels strobe at once with tready_i=1, pointer=0 -> four consecutive transfers, chn 0,1,2,3. Repeat after granting chn 1 (pointer=2) -> order 2,3,0,1.
- Backpressure: tready_i=0 for 10 cycles while ref[0] is rewritten and rpm_valid_i[0] strobes twice -> presented pair unchanged. After release, the next issue of chn 0 carries the newest sample, and overrun_o[0]=1.
- Stop and bad channel: stop_i[1]=1, ref[1]=0x0200 -> issued data_ref_o=0. tr_chn_i=5 with NUM_CHN=4 -> no reference changes.
- Watchdog with STALE_CYC=16: no strobe on chn 3 for 16 cycles -> stale_o[3]=1. Strobe -> stale_o[3]=0 next cycle. Assert rstn low mid-handshake -> all outputs return to reset values immediately.
